bcd_time_counter: RTL and testbench

//  Downstream consumer of the mod-6 seconds-carry stage: takes its overflow pulse (one per minute) and keeps

---
 rtl/bcd_time_counter.sv | 182 ++++++++++++++++++
 tb/tb_bcd_time_counter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// Minutes/hours packed-BCD time-of-day counter driven by a one-per-minute carry tick, with a
// validated time-load handshake. Define ALARM_EN to add the alarm register and alarm_hit pulse.
module bcd_time_counter #(
   parameter logic [7:0] RESET_MIN  = 8'h00,
   parameter logic [7:0] RESET_HOUR = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_in,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic [7:0] load_min,
   input  logic [7:0] load_hour,
   output logic       load_done,
   output logic       load_err,
   output logic [7:0] min_bcd,
   output logic [7:0] hour_bcd,
   output logic       carry_hour,
`ifdef ALARM_EN
   input  logic       alarm_set,
   input  logic [7:0] alarm_min,
   input  logic [7:0] alarm_hour,
   output logic       alarm_hit,
`endif
   output logic       day_pulse
);

   typedef enum logic [1:0] {StIdle, StCheck, StCommit} state_e;

   state_e     state_q, state_d;
   logic       tick_prev_q;
   logic       tick_pend_q, tick_pend_d;
   logic [7:0] min_q, min_d, hour_q, hour_d;
   logic [7:0] shadow_min_q, shadow_min_d, shadow_hour_q, shadow_hour_d;
   logic       load_done_q, load_done_d, load_err_q, load_err_d;
   logic       carry_hour_q, carry_hour_d, day_pulse_q, day_pulse_d;
   logic       rise, accept, incr, commit, legal;
   logic       wrap_mu, wrap_min, wrap_hu, wrap_day;
   logic [7:0] min_inc, hour_inc;

   assign rise   = tick_in & ~tick_prev_q;
   assign accept = (state_q == StIdle) & load_valid;

   // Per-digit BCD increment; each nibble is handled independently.
   assign wrap_mu  = (min_q[3:0] == 4'd9);
   assign wrap_min = wrap_mu & (min_q[7:4] == 4'd5);
   assign wrap_hu  = (hour_q[3:0] == 4'd9);
   assign wrap_day = wrap_min & (hour_q == 8'h23);

   always_comb begin
      min_inc[3:0] = wrap_mu ? 4'd0 : min_q[3:0] + 4'd1;
      if (wrap_min) begin
         min_inc[7:4] = 4'd0;
      end else if (wrap_mu) begin
         min_inc[7:4] = min_q[7:4] + 4'd1;
      end else begin
         min_inc[7:4] = min_q[7:4];
      end
      hour_inc = hour_q;
      if (wrap_day) begin
         hour_inc = 8'h00;
      end else if (wrap_min) begin
         hour_inc[3:0] = wrap_hu ? 4'd0 : hour_q[3:0] + 4'd1;
         hour_inc[7:4] = wrap_hu ? hour_q[7:4] + 4'd1 : hour_q[7:4];
      end
   end

   assign legal = (shadow_min_q[3:0] <= 4'd9) && (shadow_min_q[7:4] <= 4'd5) &&
                  (shadow_hour_q[3:0] <= 4'd9) && (shadow_hour_q[7:4] <= 4'd2) &&
                  (shadow_hour_q <= 8'h23);

   always_comb begin
      state_d       = state_q;
      tick_pend_d   = tick_pend_q | rise;
      min_d         = min_q;
      hour_d        = hour_q;
      shadow_min_d  = shadow_min_q;
      shadow_hour_d = shadow_hour_q;
      load_done_d   = 1'b0;
      load_err_d    = 1'b0;
      carry_hour_d  = 1'b0;
      day_pulse_d   = 1'b0;
      incr          = 1'b0;
      commit        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               // A tick arriving with the accept stays pending until the load resolves.
               shadow_min_d  = load_min;
               shadow_hour_d = load_hour;
               state_d       = StCheck;
            end else if (tick_pend_q | rise) begin
               incr         = 1'b1;
               tick_pend_d  = 1'b0;
               min_d        = min_inc;
               hour_d       = hour_inc;
               carry_hour_d = wrap_min;
               day_pulse_d  = wrap_day;
            end
         end
         StCheck: begin
            if (legal) begin
               state_d = StCommit;
            end else begin
               load_err_d = 1'b1;
               state_d    = StIdle;
            end
         end
         StCommit: begin
            commit      = 1'b1;
            min_d       = shadow_min_q;
            hour_d      = shadow_hour_q;
            load_done_d = 1'b1;
            tick_pend_d = 1'b0;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         tick_prev_q   <= 1'b0;
         tick_pend_q   <= 1'b0;
         min_q         <= RESET_MIN;
         hour_q        <= RESET_HOUR;
         shadow_min_q  <= 8'h00;
         shadow_hour_q <= 8'h00;
         load_done_q   <= 1'b0;
         load_err_q    <= 1'b0;
         carry_hour_q  <= 1'b0;
         day_pulse_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         tick_prev_q   <= tick_in;
         tick_pend_q   <= tick_pend_d;
         min_q         <= min_d;
         hour_q        <= hour_d;
         shadow_min_q  <= shadow_min_d;
         shadow_hour_q <= shadow_hour_d;
         load_done_q   <= load_done_d;
         load_err_q    <= load_err_d;
         carry_hour_q  <= carry_hour_d;
         day_pulse_q   <= day_pulse_d;
      end
   end

`ifdef ALARM_EN
   logic [15:0] alarm_q;
   logic        alarm_hit_q, alarm_hit_d;

   // Only a time change can fire, so sitting on the alarm time never repeats the pulse.
   assign alarm_hit_d = (incr | commit) && ({hour_d, min_d} == alarm_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alarm_q     <= 16'hFFFF;
         alarm_hit_q <= 1'b0;
      end else begin
         if (alarm_set) begin
            alarm_q <= {alarm_hour, alarm_min};
         end
         alarm_hit_q <= alarm_hit_d;
      end
   end

   assign alarm_hit = alarm_hit_q;
`else
   logic unused_flags;
   assign unused_flags = incr ^ commit;
`endif

   assign load_ready = (state_q == StIdle);
   assign load_done  = load_done_q;
   assign load_err   = load_err_q;
   assign min_bcd    = min_q;
   assign hour_bcd   = hour_q;
   assign carry_hour = carry_hour_q;
   assign day_pulse  = day_pulse_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed self-checking bench for bcd_time_counter; inputs driven and outputs sampled on negedge.
module tb_bcd_time_counter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_in = 1'b0;
   logic       load_valid = 1'b0;
   logic       load_ready;
   logic [7:0] load_min = 8'h00;
   logic [7:0] load_hour = 8'h00;
   logic       load_done, load_err;
   logic [7:0] min_bcd, hour_bcd;
   logic       carry_hour, day_pulse;
`ifdef ALARM_EN
   logic       alarm_set = 1'b0;
   logic [7:0] alarm_min = 8'h00;
   logic [7:0] alarm_hour = 8'h00;
   logic       alarm_hit;
`endif

   int checks = 0;
   int failures = 0;
   int n_carry = 0, n_day = 0, n_done = 0, n_err = 0, n_alarm = 0;
   int c0, d0, dn0, e0;

   always #5 clk = ~clk;

   bcd_time_counter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_in    (tick_in),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_min   (load_min),
      .load_hour  (load_hour),
      .load_done  (load_done),
      .load_err   (load_err),
      .min_bcd    (min_bcd),
      .hour_bcd   (hour_bcd),
      .carry_hour (carry_hour),
`ifdef ALARM_EN
      .alarm_set  (alarm_set),
      .alarm_min  (alarm_min),
      .alarm_hour (alarm_hour),
      .alarm_hit  (alarm_hit),
`endif
      .day_pulse  (day_pulse)
   );

   always @(negedge clk) begin
      if (carry_hour) n_carry++;
      if (day_pulse)  n_day++;
      if (load_done)  n_done++;
      if (load_err)   n_err++;
`ifdef ALARM_EN
      if (alarm_hit)  n_alarm++;
`endif
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick_pulse();
      @(negedge clk) tick_in = 1'b1;
      @(negedge clk) tick_in = 1'b0;
      @(negedge clk);
   endtask

   // Returns on the negedge right after the accepting posedge.
   task automatic do_load(input logic [7:0] m, input logic [7:0] h);
      int budget = 20;
      @(negedge clk);
      while (!load_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check_eq("ready_wait", {31'd0, load_ready}, 32'd1);
      load_valid = 1'b1;
      load_min   = m;
      load_hour  = h;
      @(posedge clk);
      @(negedge clk) load_valid = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_eq("rst_min", {24'd0, min_bcd}, 32'h00);
      check_eq("rst_hour", {24'd0, hour_bcd}, 32'h00);
      check_eq("rst_ready", {31'd0, load_ready}, 32'd1);
      check_eq("rst_pulses", {28'd0, carry_hour, day_pulse, load_done, load_err}, 32'd0);
      rst_n = 1'b1;

      // Ten rises from reset.
      for (int i = 0; i < 10; i++) tick_pulse();
      check_eq("t1_min", {24'd0, min_bcd}, 32'h10);
      check_eq("t1_hour", {24'd0, hour_bcd}, 32'h00);
      check_eq("t1_carry_cnt", n_carry, 32'd0);
      check_eq("t1_day_cnt", n_day, 32'd0);

      // Load 23:59, commit timing, then day wrap.
      do_load(8'h59, 8'h23);
      check_eq("t2_busy", {31'd0, load_ready}, 32'd0);
      @(negedge clk);
      check_eq("t2_done_early", {31'd0, load_done}, 32'd0);
      @(negedge clk);
      check_eq("t2_done", {31'd0, load_done}, 32'd1);
      check_eq("t2_loaded", {16'd0, hour_bcd, min_bcd}, 32'h2359);
      @(negedge clk);
      check_eq("t2_done_width", {31'd0, load_done}, 32'd0);
      tick_in = 1'b1;
      @(negedge clk);
      check_eq("t2_wrap_time", {16'd0, hour_bcd, min_bcd}, 32'h0000);
      check_eq("t2_pulses", {30'd0, carry_hour, day_pulse}, 32'd3);
      @(negedge clk);
      check_eq("t2_pulses_off", {30'd0, carry_hour, day_pulse}, 32'd0);

      // tick_in continues high for 20 clk in total: one increment only.
      c0 = n_carry;
      repeat (18) @(negedge clk);
      tick_in = 1'b0;
      tick_in = 1'b1;
      @(negedge clk) tick_in = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("t3_hold_time", {16'd0, hour_bcd, min_bcd}, 32'h0000);
      tick_in = 1'b1;
      repeat (20) @(negedge clk);
      tick_in = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("t3_one_inc", {16'd0, hour_bcd, min_bcd}, 32'h0001);
      check_eq("t3_no_carry", n_carry - c0, 32'd0);

      // Illegal loads.
      do_load(8'h60, 8'h12);
      check_eq("t4_err_early", {31'd0, load_err}, 32'd0);
      @(negedge clk);
      check_eq("t4_err", {31'd0, load_err}, 32'd1);
      check_eq("t4_ready_back", {31'd0, load_ready}, 32'd1);
      @(negedge clk);
      check_eq("t4_err_width", {31'd0, load_err}, 32'd0);
      check_eq("t4_time_kept", {16'd0, hour_bcd, min_bcd}, 32'h0001);
      e0 = n_err;
      dn0 = n_done;
      do_load(8'h30, 8'h24);
      repeat (4) @(negedge clk);
      check_eq("t4_err2_cnt", n_err - e0, 32'd1);
      check_eq("t4_no_done", n_done - dn0, 32'd0);
      check_eq("t4_time_kept2", {16'd0, hour_bcd, min_bcd}, 32'h0001);

      // Hour units wrap 09:59 -> 10:00.
      do_load(8'h59, 8'h09);
      repeat (3) @(negedge clk);
      c0 = n_carry;
      d0 = n_day;
      tick_pulse();
      check_eq("hu_wrap_time", {16'd0, hour_bcd, min_bcd}, 32'h1000);
      check_eq("hu_carry_cnt", n_carry - c0, 32'd1);
      check_eq("hu_no_day", n_day - d0, 32'd0);

      // Rise during check of a legal load is discarded by the commit.
      do_load(8'h15, 8'h07);
      tick_in = 1'b1;
      repeat (4) @(negedge clk);
      tick_in = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("t5_commit_wins", {16'd0, hour_bcd, min_bcd}, 32'h0715);

      // Rise during check of an illegal load is applied afterwards.
      e0 = n_err;
      do_load(8'h7A, 8'h07);
      tick_in = 1'b1;
      repeat (4) @(negedge clk);
      tick_in = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("t5_held_tick", {16'd0, hour_bcd, min_bcd}, 32'h0716);
      check_eq("t5_err_cnt", n_err - e0, 32'd1);

`ifdef ALARM_EN
      do_load(8'h15, 8'h07);
      repeat (3) @(negedge clk);
      alarm_set  = 1'b1;
      alarm_min  = 8'h16;
      alarm_hour = 8'h07;
      @(negedge clk) alarm_set = 1'b0;
      @(negedge clk);
      check_eq("al_quiet", n_alarm, 32'd0);
      tick_in = 1'b1;
      @(negedge clk);
      check_eq("al_hit", {31'd0, alarm_hit}, 32'd1);
      @(negedge clk);
      check_eq("al_hit_width", {31'd0, alarm_hit}, 32'd0);
      tick_in = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("al_hit_cnt", n_alarm, 32'd1);
`endif

      // Reset while a load is in check aborts it silently.
      dn0 = n_done;
      e0 = n_err;
      do_load(8'h45, 8'h10);
      rst_n = 1'b0;
      #1;
      check_eq("rm_time", {16'd0, hour_bcd, min_bcd}, 32'h0000);
      check_eq("rm_ready", {31'd0, load_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("rm_no_done", n_done - dn0, 32'd0);
      check_eq("rm_no_err", n_err - e0, 32'd0);
      check_eq("rm_time_after", {16'd0, hour_bcd, min_bcd}, 32'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
